// File: rtl/ps2_pkg.sv
//------------------------------------------------------------------------------
// Module  : ps2_pkg
// Brief   : Shared PS/2 receiver types and frame constants.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module  : sync_fifo
// Brief   : Single-clock first-word-fall-through FIFO with occupancy output.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);
    localparam int              C_AW   = $clog2(DEPTH);
    localparam logic [C_AW:0]   C_FULL = DEPTH[C_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wptr;
    logic [C_AW-1:0]  r_rptr;
    logic [C_AW:0]    r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_FULL);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow <= i_push & w_full & ~w_do_pop;
        end
    end

    assign o_data     = w_empty ? '0 : r_mem[r_rptr];
    assign o_valid    = ~w_empty;
    assign o_level    = r_count;
    assign o_overflow = r_overflow;
endmodule

`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
//------------------------------------------------------------------------------
// Module  : ps2_rx_fifo
// Brief   : PS/2 device-to-host receiver with glitch filter, timeout and FIFO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int SYNC_LEN   = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 10000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          ps2_clk_inhibit,
    output logic [7:0]                    code,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          timeout_err,
    output logic                          overflow
);
    localparam int                C_LW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [C_LW-1:0]   C_FULL = FIFO_DEPTH[C_LW-1:0];
    localparam int                C_TW   = $clog2(TIMEOUT + 1);
    localparam logic [C_TW-1:0]   C_TMO  = TIMEOUT[C_TW-1:0];
    localparam int                C_CW   = $clog2(DATA_BITS);
    localparam logic [C_CW-1:0]   C_LAST = C_CW'(DATA_BITS - 1);

    logic                r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [SYNC_LEN-1:0] r_hist;
    logic                r_fclk;
    ps2_state_t          r_state, w_state_nxt;
    logic [7:0]          r_shift;
    logic [C_CW-1:0]     r_cnt;
    logic                r_par;
    logic [C_TW-1:0]     r_tmo;
    logic                r_parity_err, r_frame_err, r_timeout_err, r_inhibit;

    logic                w_fall, w_tmo_hit;
    logic                w_push, w_parity_err, w_frame_err;
    logic [C_LW-1:0]     w_level;

    // Line idles high, so everything upstream of the edge detector resets to 1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_hist   <= '1;
            r_fclk   <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_hist   <= {r_hist[SYNC_LEN-2:0], r_clk_s2};
            if (&r_hist)       r_fclk <= 1'b1;
            else if (~|r_hist) r_fclk <= 1'b0;
        end
    end

    assign w_fall    = r_fclk & ~|r_hist;
    assign w_tmo_hit = (r_state != ST_IDLE) && (r_tmo >= C_TMO);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_tmo_hit) begin
            w_state_nxt = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (r_dat_s2 == START_BIT) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_cnt == C_LAST) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP:   w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_push       = 1'b0;
        w_parity_err = 1'b0;
        w_frame_err  = 1'b0;
        if (!w_tmo_hit && w_fall && r_state == ST_STOP) begin
            if (r_dat_s2 != STOP_BIT) w_frame_err  = 1'b1;
            else if (!r_par)          w_parity_err = 1'b1;
            else                      w_push       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_tmo   <= '0;
        end else begin
            if (r_state == ST_IDLE || w_fall) r_tmo <= '0;
            else                              r_tmo <= r_tmo + 1'b1;
            if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt <= '0;
                        r_par <= 1'b0;
                    end
                    ST_DATA: begin
                        r_shift <= {r_dat_s2, r_shift[7:1]};
                        r_par   <= r_par ^ r_dat_s2;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                    ST_PARITY: r_par <= r_par ^ r_dat_s2;
                    default:   r_par <= r_par;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_inhibit     <= 1'b0;
        end else begin
            r_parity_err  <= w_parity_err;
            r_frame_err   <= w_frame_err;
            r_timeout_err <= w_tmo_hit;
            // Only hold the device off between frames, never once a start bit is seen.
            r_inhibit     <= (w_level == C_FULL) && (r_state == ST_IDLE)
                             && (w_state_nxt == ST_IDLE);
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (w_push),
        .i_data     (r_shift),
        .i_pop      (code_ready),
        .o_data     (code),
        .o_valid    (code_valid),
        .o_level    (w_level),
        .o_overflow (overflow)
    );

    assign level           = w_level;
    assign parity_err      = r_parity_err;
    assign frame_err       = r_frame_err;
    assign timeout_err     = r_timeout_err;
    assign ps2_clk_inhibit = r_inhibit;
endmodule

`default_nettype wire
